// File: rtl/seq_monitor_if.sv
// seq_monitor_if: sample/result bundle between the shift register tap and seq_monitor.
// SEQ_MONITOR_PERIOD_EN adds the period result.
interface seq_monitor_if #(parameter int CNT_W = 4);
    logic [2:0] Qin;
    logic en;
    logic hit;
    logic [CNT_W-1:0] hit_cnt;
    logic stuck;
    logic [1:0] state;
`ifdef SEQ_MONITOR_PERIOD_EN
    logic [7:0] period;
    modport master (output Qin, en, input hit, hit_cnt, stuck, state, period);
    modport slave (input Qin, en, output hit, hit_cnt, stuck, state, period);
`else
    modport master (output Qin, en, input hit, hit_cnt, stuck, state);
    modport slave (input Qin, en, output hit, hit_cnt, stuck, state);
`endif
endinterface

// File: rtl/seq_monitor.sv
// seq_monitor: detects PAT0,PAT1,PAT2 on a 3-bit register tap, counts hits, flags a stuck tap.
// SEQ_MONITOR_PERIOD_EN adds a hit-to-hit period measurement.
module seq_monitor #(
    parameter logic [2:0] PAT0 = 3'b001,
    parameter logic [2:0] PAT1 = 3'b010,
    parameter logic [2:0] PAT2 = 3'b100,
    parameter int CNT_W = 4,
    parameter int STUCK_LIM = 4
) (
    input logic clk,
    input logic rst,
    seq_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GOT0 = 2'd1, GOT1 = 2'd2} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0] LIM = 4'(STUCK_LIM);
    state_t state_q, state_n;
    logic hit_q, stuck_q, prev_valid, done;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0] prev_q;
    logic [3:0] rep_q, rep_n;
    // Only the PAT0 fallback is reused on a mismatch or after a completed sequence.
    always_comb begin
        done = state_q == GOT1 && bus.Qin == PAT2;
        state_n = (state_q == GOT0 && bus.Qin == PAT1) ? GOT1 : (bus.Qin == PAT0 ? GOT0 : IDLE);
        rep_n = !prev_valid ? rep_q : (bus.Qin != prev_q ? 4'd0 : (rep_q >= LIM ? LIM : rep_q + 4'd1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hit_q <= 1'b0;
            cnt_q <= '0;
            stuck_q <= 1'b0;
            prev_q <= '0;
            prev_valid <= 1'b0;
            rep_q <= '0;
        end else begin
            hit_q <= bus.en && done;
            if (bus.en) begin
                state_q <= state_n;
                cnt_q <= (done && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
                prev_q <= bus.Qin;
                prev_valid <= 1'b1;
                rep_q <= rep_n;
                stuck_q <= rep_n >= LIM;
            end
        end
    end
    assign bus.hit = hit_q;
    assign bus.hit_cnt = cnt_q;
    assign bus.stuck = stuck_q;
    assign bus.state = state_q;
`ifdef SEQ_MONITOR_PERIOD_EN
    logic [7:0] since_q, period_q;
    logic armed_q;
    // The first hit only arms; later hits report samples elapsed since the previous hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            since_q <= '0;
            period_q <= '0;
            armed_q <= 1'b0;
        end else if (bus.en) begin
            if (done) begin
                since_q <= '0;
                armed_q <= 1'b1;
                if (armed_q) period_q <= since_q == 8'hff ? 8'hff : since_q + 8'd1;
            end else begin
                since_q <= since_q == 8'hff ? since_q : since_q + 8'd1;
            end
        end
    end
    assign bus.period = period_q;
`endif
endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor: directed vectors push expected outputs; a monitor pops and compares after each edge.
module tb_seq_monitor;
    localparam logic [2:0] A = 3'b001, B = 3'b010, C = 3'b100, T = 3'b011, Y = 3'b110, W = 3'b111;
    typedef struct {
        logic h;
        logic [3:0] c;
        logic s;
        logic [1:0] st;
        logic [7:0] p;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0;
    int nerr = 0;
    exp_t sb[$];
    seq_monitor_if #(.CNT_W(4)) bus ();
    seq_monitor dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic v(input logic r, input logic e, input logic [2:0] q, input logic h,
                     input logic [3:0] c, input logic s, input logic [1:0] st, input logic [7:0] p);
        @(negedge clk);
        rst = r;
        bus.en = e;
        bus.Qin = q;
        sb.push_back('{h, c, s, st, p});
    endtask
    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
        if (a !== x) begin
            nerr++;
            $display("FAIL %s vec %0d: got %0d expected %0d", n, nvec, a, x);
        end
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                nvec++;
                chk("hit", {7'd0, bus.hit}, {7'd0, e.h});
                chk("hit_cnt", {4'd0, bus.hit_cnt}, {4'd0, e.c});
                chk("stuck", {7'd0, bus.stuck}, {7'd0, e.s});
                chk("state", {6'd0, bus.state}, {6'd0, e.st});
`ifdef SEQ_MONITOR_PERIOD_EN
                chk("period", bus.period, e.p);
`endif
            end
        end
    end
    initial begin
        bus.en = 1'b0;
        bus.Qin = 3'b000;
        v(1, 0, 3'b000, 0, 0, 0, 0, 0);
        v(0, 1, A, 0, 0, 0, 1, 0); v(0, 1, B, 0, 0, 0, 2, 0); v(0, 1, C, 1, 1, 0, 0, 0);
        v(0, 1, A, 0, 1, 0, 1, 0); v(0, 1, B, 0, 1, 0, 2, 0); v(0, 1, C, 1, 2, 0, 0, 3);
        v(0, 1, A, 0, 2, 0, 1, 3); v(0, 1, B, 0, 2, 0, 2, 3); v(0, 1, C, 1, 3, 0, 0, 3);
        v(1, 1, A, 0, 0, 0, 0, 0);
        v(0, 1, A, 0, 0, 0, 1, 0); v(0, 1, A, 0, 0, 0, 1, 0); v(0, 1, B, 0, 0, 0, 2, 0);
        v(0, 1, C, 1, 1, 0, 0, 0); v(0, 1, A, 0, 1, 0, 1, 0); v(0, 1, B, 0, 1, 0, 2, 0);
        v(0, 1, T, 0, 1, 0, 0, 0);
        v(1, 0, 3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(0, 1, T, 0, 0, 0, 0, 0);
        v(0, 1, T, 0, 0, 1, 0, 0);
        v(0, 1, Y, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(0, 1, T, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) v(0, 0, T, 0, 0, 0, 0, 0);
        v(0, 1, T, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) v(0, 0, Y, 0, 0, 1, 0, 0);
        v(0, 1, Y, 0, 0, 0, 0, 0);
        v(0, 1, A, 0, 0, 0, 1, 0); v(0, 1, B, 0, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) v(0, 0, W, 0, 0, 0, 2, 0);
        v(0, 1, C, 1, 1, 0, 0, 0);
        v(1, 0, 3'b000, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            v(0, 1, A, 0, 4'(k - 1 > 15 ? 15 : k - 1), 0, 1, k >= 3 ? 8'd3 : 8'd0);
            v(0, 1, B, 0, 4'(k - 1 > 15 ? 15 : k - 1), 0, 2, k >= 3 ? 8'd3 : 8'd0);
            v(0, 1, C, 1, 4'(k > 15 ? 15 : k), 0, 0, k >= 2 ? 8'd3 : 8'd0);
        end
        v(0, 1, A, 0, 15, 0, 1, 3); v(0, 1, B, 0, 15, 0, 2, 3);
        v(1, 1, C, 0, 0, 0, 0, 0);
        v(0, 1, C, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
